// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one single-ported SRAM between the fetch port and the load/store port
// Optional ARB_PERF_CNT_EN adds per-port wait-cycle counters.
module sram_port_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int WAIT_STATES    = 1,
    parameter int MEM_STREAK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_ack,
    output logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] sram_a,
    output logic          sram_re,
    output logic          sram_we,
    output logic          sram_oe,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   if_wait_cycles,
    output logic [31:0]   mem_wait_cycles
`endif
);

    localparam int SW = ($clog2(MEM_STREAK_MAX + 1) > 3) ? $clog2(MEM_STREAK_MAX + 1) : 3;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    wait_cnt;
    logic          sel_mem;
    logic          lat_we;
    logic [SW-1:0] streak_cnt;
    logic          grant_any;
    logic          grant_mem;

    // MEM is preferred unless IF has been starved for MEM_STREAK_MAX grants.
    always_comb begin
        state_nxt = state;
        grant_any = 1'b0;
        grant_mem = 1'b0;
        case (state)
            S_IDLE: begin
                if (if_req || mem_req) begin
                    grant_any = 1'b1;
                    grant_mem = mem_req && !(if_req && streak_cnt == SW'(MEM_STREAK_MAX));
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wait_cnt == 4'd0) state_nxt = S_DONE;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            sel_mem    <= 1'b0;
            lat_we     <= 1'b0;
            sram_a     <= '0;
            sram_wdata <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            streak_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                sel_mem  <= grant_mem;
                lat_we   <= grant_mem & mem_we;
                sram_a   <= grant_mem ? mem_addr : if_addr;
                wait_cnt <= 4'(WAIT_STATES);
                if (grant_mem) sram_wdata <= mem_wdata;
            end else if (state == S_ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == S_ACCESS && wait_cnt == 4'd0 && !lat_we) begin
                if (sel_mem) mem_rdata <= sram_rdata;
                else         if_rdata  <= sram_rdata;
            end
            if (grant_any && !grant_mem)
                streak_cnt <= '0;
            else if (state == S_IDLE && !if_req)
                streak_cnt <= '0;
            else if (grant_mem && if_req && streak_cnt < SW'(MEM_STREAK_MAX))
                streak_cnt <= streak_cnt + 1'b1;
        end
    end

    assign sram_re = (state == S_ACCESS) && !lat_we;
    assign sram_we = (state == S_ACCESS) && lat_we;
    assign sram_oe = sram_we;
    assign if_ack  = (state == S_DONE) && !sel_mem;
    assign mem_ack = (state == S_DONE) && sel_mem;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_wait_cycles  <= 32'd0;
            mem_wait_cycles <= 32'd0;
        end else begin
            if (if_req && !if_ack)   if_wait_cycles  <= if_wait_cycles + 32'd1;
            if (mem_req && !mem_ack) mem_wait_cycles <= mem_wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed checks of the SRAM port arbiter (WAIT_STATES=1 and WAIT_STATES=0 instances)
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, if_ack, mem_req, mem_we, mem_ack;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] sram_a, sram_wdata, sram_rdata;
    logic        sram_re, sram_we, sram_oe;

    logic        z_if_req, z_if_ack, z_mem_req, z_mem_we, z_mem_ack;
    logic [31:0] z_if_addr, z_if_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;
    logic [31:0] z_sram_a, z_sram_wdata, z_sram_rdata;
    logic        z_sram_re, z_sram_we, z_sram_oe;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] p0_if_wait, p0_mem_wait, p1_if_wait, p1_mem_wait;
`endif

    sram_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(1), .MEM_STREAK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sram_a(sram_a), .sram_re(sram_re), .sram_we(sram_we), .sram_oe(sram_oe),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef ARB_PERF_CNT_EN
        , .if_wait_cycles(p0_if_wait), .mem_wait_cycles(p0_mem_wait)
`endif
    );

    sram_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(0), .MEM_STREAK_MAX(4)) dut_ws0 (
        .clk(clk), .rst(rst),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_ack(z_if_ack), .if_rdata(z_if_rdata),
        .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_ack(z_mem_ack), .mem_rdata(z_mem_rdata),
        .sram_a(z_sram_a), .sram_re(z_sram_re), .sram_we(z_sram_we), .sram_oe(z_sram_oe),
        .sram_wdata(z_sram_wdata), .sram_rdata(z_sram_rdata)
`ifdef ARB_PERF_CNT_EN
        , .if_wait_cycles(p1_if_wait), .mem_wait_cycles(p1_mem_wait)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [31:0] exp_if;
        logic [31:0] exp_mem;
        int          exp_lat;
        int          exp_re;
        int          exp_we;
    } vec_t;

    vec_t vecs[5];

    // One single-requester access on the WAIT_STATES=1 instance; starts and ends at a negedge.
    task automatic run_txn(input vec_t v, input string tag);
        int cyc = 0, re_n = 0, we_n = 0, bad_addr = 0, bad_data = 0, other_ack = 0;
        bit got = 0;
        sram_rdata = v.rd;
        if (v.is_mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        while (!got && cyc < 20) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if ((sram_re || sram_we) && sram_a !== v.addr) bad_addr++;
            if (sram_re) re_n++;
            if (sram_we && sram_oe) begin
                we_n++;
                if (sram_wdata !== v.wdata) bad_data++;
            end
            if (v.is_mem ? if_ack : mem_ack) other_ack++;
            if (v.is_mem ? mem_ack : if_ack) got = 1;
        end
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        chk({tag, " ack seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, cyc, v.exp_lat);
        chk({tag, " re cycles"}, re_n, v.exp_re);
        chk({tag, " we&oe cycles"}, we_n, v.exp_we);
        chk({tag, " sram_a errors"}, bad_addr, 0);
        chk({tag, " sram_wdata errors"}, bad_data, 0);
        chk({tag, " wrong ack"}, other_ack, 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " if_rdata"}, if_rdata, v.exp_if);
        chk({tag, " mem_rdata"}, mem_rdata, v.exp_mem);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, t_mem, t_if, both, n, noise, re_n;
        logic [9:0] seq;
        vec_t pv;

        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        3, 2, 0};
        vecs[1] = '{1'b1, 1'b1, 32'h100, 32'h12345678, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0,        3, 0, 2};
        vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 3, 2, 0};
        vecs[3] = '{1'b1, 1'b1, 32'h204, 32'hAAAA5555, 32'h11111111, 32'hDEADBEEF, 32'hCAFEF00D, 3, 0, 2};
        vecs[4] = '{1'b0, 1'b0, 32'h44,  32'h0,        32'h01020304, 32'h01020304, 32'hCAFEF00D, 3, 2, 0};

        rst = 1'b0;
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; sram_rdata = 0;
        z_if_req = 0; z_if_addr = 0; z_mem_req = 0; z_mem_we = 0; z_mem_addr = 0; z_mem_wdata = 0;
        z_sram_rdata = 0;
        @(negedge clk);
        @(negedge clk);
        chk("reset acks", {30'd0, if_ack, mem_ack}, 32'd0);
        chk("reset strobes", {29'd0, sram_re, sram_we, sram_oe}, 32'd0);
        chk("reset if_rdata", if_rdata, 32'd0);
        chk("reset mem_rdata", mem_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a store access.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        chk("pre-reset store strobe", 32'(sram_we), 32'd1);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midreset sram_we", 32'(sram_we), 32'd0);
        chk("midreset acks", {30'd0, if_ack, mem_ack}, 32'd0);
        chk("midreset if_rdata", if_rdata, 32'd0);
        chk("midreset mem_rdata", mem_rdata, 32'd0);
        mem_req = 1'b0; mem_we = 1'b0;
        rst = 1'b1;
        noise = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if_ack || mem_ack || sram_re || sram_we || sram_oe) noise++;
        end
        chk("post-reset quiet", noise, 0);
        pv = '{1'b0, 1'b0, 32'h48, 32'h0, 32'h77777777, 32'h77777777, 32'h0, 3, 2, 0};
        run_txn(pv, "post-reset read");

        // Simultaneous requests: MEM first, IF one access slot later.
        sram_rdata = 32'h13572468;
        if_req = 1'b1; if_addr = 32'h50; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500;
        cyc = 0; t_mem = 0; t_if = 0; both = 0;
        while ((t_mem == 0 || t_if == 0) && cyc < 30) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (if_ack && mem_ack) both++;
            if (mem_ack) begin t_mem = cyc; mem_req = 1'b0; end
            if (if_ack)  begin t_if = cyc;  if_req = 1'b0; end
        end
        chk("simul mem ack cycle", t_mem, 3);
        chk("simul if ack cycle", t_if, 7);
        chk("simul both acks", both, 0);
        chk("simul mem_rdata", mem_rdata, 32'h13572468);
        chk("simul if_rdata", if_rdata, 32'h13572468);
        @(negedge clk);

        // Both held: four MEM grants then one IF grant, repeating.
        if_req = 1'b1; if_addr = 32'h60; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h600;
        seq = '0; n = 0; cyc = 0; both = 0;
        while (n < 10 && cyc < 80) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (if_ack && mem_ack) both++;
            if (mem_ack) begin seq[n] = 1'b1; n++; end
            else if (if_ack) begin seq[n] = 1'b0; n++; end
        end
        if_req = 1'b0; mem_req = 1'b0;
        chk("streak grant count", n, 10);
        chk("streak pattern", 32'(seq), 32'(10'b0111101111));
        chk("streak both acks", both, 0);
        @(negedge clk);
        @(negedge clk);

        // WAIT_STATES=0 instance: single IF read.
        z_sram_rdata = 32'h5A5A5A5A;
        z_if_req = 1'b1; z_if_addr = 32'h80;
        cyc = 0; re_n = 0;
        while (!z_if_ack && cyc < 10) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (z_sram_re && z_sram_a === 32'h80) re_n++;
        end
        z_if_req = 1'b0;
        chk("ws0 latency", cyc, 2);
        chk("ws0 re cycles", re_n, 1);
        chk("ws0 if_rdata", z_if_rdata, 32'h5A5A5A5A);
        @(negedge clk);
`ifdef ARB_PERF_CNT_EN
        chk("ws0 if_wait_cycles", p1_if_wait, 32'd2);
        chk("ws0 mem_wait_cycles", p1_mem_wait, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
